// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI peripheral endpoint, oversampled bus, all CPOL/CPHA modes, multi-byte frames
//
// Purpose:
//   Samples SCLK, CS_n and MOSI with i_Clk (at least 8x SCLK). It shifts MOSI
//   bytes in and MISO bytes out, MSB first. Several bytes may share one CS low
//   pulse. Bytes to send are written into a one-entry holding register.
//
// Ports:
//   i_Clk, i_Rst           system clock, synchronous active-high reset
//   i_CPOL, i_CPHA         bus mode, captured only while CS_n is high
//   i_TX_Byte, i_TX_DV     TX holding register write
//   o_TX_Ready             holding register empty
//   o_RX_DV, o_RX_Byte     one-cycle pulse with a completed received byte
//   o_RX_Count             bytes received in the current frame (saturating)
//   o_Frame_Done           pulse when CS_n rises after an active frame
//   o_Frame_Err            pulse when CS_n rises during a partial byte
//   i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI   asynchronous bus inputs
//   o_SPI_MISO             serial data out
//   o_SPI_MISO_OE          MISO output enable (only with SPI_SLAVE_MISO_OE_EN)
//
// Build option:
//   SPI_SLAVE_MISO_OE_EN - adds o_SPI_MISO_OE. MISO is then 0 while not driving.

module spi_slave #(
    parameter int         MAX_BYTES_PER_CS = 10,
    parameter logic [7:0] IDLE_TX_BYTE     = 8'h00,
    localparam int        CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_CPOL,
    input  logic          i_CPHA,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_DV,
    output logic          o_TX_Ready,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_Frame_Done,
    output logic          o_Frame_Err,
    input  logic          i_SPI_Clk,
    input  logic          i_SPI_CS_n,
    input  logic          i_SPI_MOSI,
`ifdef SPI_SLAVE_MISO_OE_EN
    output logic          o_SPI_MISO_OE,
`endif
    output logic          o_SPI_MISO
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t          state_q, state_d;
    logic            sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic            cs_s1_q, cs_s2_q, cs_s3_q;
    logic            mosi_s1_q, mosi_s2_q;
    logic            cpol_q, cpol_d, cpha_q, cpha_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   rx_count_q, rx_count_d;
    logic            rx_dv_q, rx_dv_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            first_q, first_d;
    logic            load;

    // CS synchronisers reset low: a falling edge needs CS seen high first,
    // so a frame already in progress at reset exit is ignored.
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, drive_edge;
    logic cs_fall, cs_rise, tx_write, byte_boundary;
    logic [7:0] next_tx;

    assign sclk_rise   = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall   = ~sclk_s2_q & sclk_s3_q;
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign drive_edge  = cpha_q ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_s2_q & cs_s3_q;
    assign cs_rise     = cs_s2_q & ~cs_s3_q;
    assign tx_write    = i_TX_DV & ~hold_full_q;
    assign next_tx     = hold_full_q ? hold_q : IDLE_TX_BYTE;
    // A count of 8 means the completion cycle has not run yet; it is still a boundary.
    assign byte_boundary = (bit_cnt_q == 4'd0) || (bit_cnt_q == 4'd8);

    always_comb begin
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_byte_d   = rx_byte_q;
        bit_cnt_d   = bit_cnt_q;
        rx_count_d  = rx_count_q;
        rx_dv_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        first_d     = first_q;
        load        = 1'b0;

        if (cs_s2_q) begin
            cpol_d = i_CPOL;
            cpha_d = i_CPHA;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_ACTIVE;
                    load       = 1'b1;
                    bit_cnt_d  = 4'd0;
                    rx_count_d = '0;
                    first_d    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (bit_cnt_q == 4'd8) begin
                    rx_byte_d = rx_shift_q;
                    rx_dv_d   = 1'b1;
                    bit_cnt_d = 4'd0;
                    if (rx_count_q < CW'(MAX_BYTES_PER_CS))
                        rx_count_d = rx_count_q + CW'(1);
                end
                if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_s2_q};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                end
                if (drive_edge) begin
                    first_d = 1'b0;
                    // CPHA=1: the first leading edge keeps the preloaded MSB on the wire.
                    if (cpha_q && first_q)
                        tx_shift_d = tx_shift_q;
                    else if (byte_boundary)
                        load = 1'b1;
                    else
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = ~byte_boundary;
                    if (bit_cnt_q != 4'd8)
                        bit_cnt_d = 4'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            tx_shift_d = next_tx;
            if (hold_full_q)
                hold_full_d = 1'b0;
        end
        // Writes are only accepted while empty, so a same-cycle load sees the old (empty) state.
        if (tx_write) begin
            hold_d      = i_TX_Byte;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= ST_IDLE;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_s3_q   <= 1'b0;
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            cs_s3_q     <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            tx_shift_q  <= 8'h00;
            rx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            rx_byte_q   <= 8'h00;
            bit_cnt_q   <= 4'd0;
            rx_count_q  <= '0;
            rx_dv_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_s1_q   <= i_SPI_Clk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_s3_q   <= sclk_s2_q;
            cs_s1_q     <= i_SPI_CS_n;
            cs_s2_q     <= cs_s1_q;
            cs_s3_q     <= cs_s2_q;
            mosi_s1_q   <= i_SPI_MOSI;
            mosi_s2_q   <= mosi_s1_q;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_byte_q   <= rx_byte_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_count_q  <= rx_count_d;
            rx_dv_q     <= rx_dv_d;
            done_q      <= done_d;
            err_q       <= err_d;
            first_q     <= first_d;
        end
    end

    assign o_TX_Ready   = ~hold_full_q;
    assign o_RX_DV      = rx_dv_q;
    assign o_RX_Byte    = rx_byte_q;
    assign o_RX_Count   = rx_count_q;
    assign o_Frame_Done = done_q;
    assign o_Frame_Err  = err_q;

`ifdef SPI_SLAVE_MISO_OE_EN
    assign o_SPI_MISO_OE = (state_q == ST_ACTIVE);
    assign o_SPI_MISO    = (state_q == ST_ACTIVE) ? tx_shift_q[7] : 1'b0;
`else
    assign o_SPI_MISO    = (state_q == ST_ACTIVE) ? tx_shift_q[7] : 1'b1;
`endif

endmodule
